// File: rtl/chrisruk_matrix_pkg.sv
// Shared types and constants for the LED-strip matrix receiver.
// Frame layout, FSM states, pixel record and serpentine decode helper.
package chrisruk_matrix_pkg;

    localparam int START_ZEROS = 32;
    localparam int FRAME_BITS  = 32;
    localparam logic [2:0] HDR = 3'b111;

    localparam int BRIGHT_HI = 28;
    localparam int BRIGHT_LO = 24;
    localparam int B_HI      = 23;
    localparam int B_LO      = 16;
    localparam int G_HI      = 15;
    localparam int G_LO      = 8;
    localparam int R_HI      = 7;
    localparam int R_LO      = 0;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        LED,
        GAP
    } state_t;

    typedef struct packed {
        logic [4:0] bright;
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
        logic [2:0] x;
        logic [2:0] y;
    } pix_t;

    // Even rows run right-to-left on a serpentine strip.
    function automatic pix_t make_pix(
        input logic [28:0] data,
        input int          p,
        input int          mat_w
    );
        int   row;
        int   col;
        pix_t pix;
        row        = p / mat_w;
        col        = p % mat_w;
        pix.bright = data[BRIGHT_HI:BRIGHT_LO];
        pix.b      = data[B_HI:B_LO];
        pix.g      = data[G_HI:G_LO];
        pix.r      = data[R_HI:R_LO];
        pix.y      = 3'(row);
        pix.x      = row[0] ? 3'(col) : 3'(mat_w - 1 - col);
        return pix;
    endfunction

endpackage

// File: rtl/chrisruk_pix_fifo.sv
// Show-ahead synchronous FIFO for decoded pixels.
// Ports: i_wr/i_wr_data push, i_rd pop, o_rd_data head, o_full/o_empty status.
module chrisruk_pix_fifo
    import chrisruk_matrix_pkg::*;
#(
    parameter int WIDTH = $bits(pix_t),
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_rd_ok;
    logic             w_wr_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot a push on a full FIFO needs.
    assign w_rd_ok = i_rd & ~o_empty;
    assign w_wr_ok = i_wr & (~o_full | w_rd_ok);

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/chrisruk_matrix_rx.sv
// Receiver for the 2-wire LED-strip link: syncs strip clock/data, frames
// LED words, decodes serpentine x/y and streams pixels out through a FIFO.
// Ports: clk/reset; sclk_in/sdat_in strip wires; pix_* valid/ready stream;
// frame_done pulse; hdr_err and ovf sticky flags.
module chrisruk_matrix_rx
    import chrisruk_matrix_pkg::*;
#(
    parameter int MAT_W        = 8,
    parameter int MAX_PIXELS   = 64,
    parameter int FIFO_DEPTH   = 4,
    parameter int IDLE_TIMEOUT = 4095
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_in,
    input  logic       sdat_in,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic [4:0] pix_bright,
    output logic [7:0] pix_b,
    output logic [7:0] pix_g,
    output logic [7:0] pix_r,
    output logic [2:0] pix_x,
    output logic [2:0] pix_y,
    output logic       frame_done,
    output logic       hdr_err,
    output logic       ovf
);
    localparam int CW = 6;
    localparam int PW = $clog2(MAX_PIXELS + 1);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CW-1:0] ZLAST = CW'(START_ZEROS - 1);
    localparam logic [CW-1:0] BLAST = CW'(FRAME_BITS - 1);

    logic                  r_sclk_meta;
    logic                  r_sclk_sync;
    logic                  r_sclk_prev;
    logic                  r_sdat_meta;
    logic                  r_sdat_sync;
    state_t                r_state;
    logic [CW-1:0]         r_zcnt;
    logic [CW-1:0]         r_bcnt;
    logic [FRAME_BITS-2:0] r_shift;
    logic [PW-1:0]         r_pidx;
    logic [TW-1:0]         r_idle_cnt;
    logic                  r_done;
    logic                  r_hdr_err;
    logic                  r_ovf;

    logic                  w_fall;
    logic                  w_bit;
    logic                  w_tmo;
    logic [FRAME_BITS-1:0] w_word;
    state_t                w_state_nxt;
    logic [CW-1:0]         w_zcnt_nxt;
    logic [CW-1:0]         w_bcnt_nxt;
    logic [FRAME_BITS-2:0] w_shift_nxt;
    logic [PW-1:0]         w_pidx_nxt;
    logic                  w_frame_ok;
    logic                  w_hdr_bad;
    logic                  w_done;
    logic                  w_room;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_ovf_set;
    pix_t                  w_pix;
    pix_t                  w_head;
    logic [$bits(pix_t)-1:0] w_rd_data;

    // Transmitter updates data on the rise, so sample on the synced fall.
    assign w_fall = r_sclk_prev & ~r_sclk_sync;
    assign w_bit  = r_sdat_sync;
    assign w_tmo  = ~w_fall && (r_idle_cnt == TW'(IDLE_TIMEOUT));
    assign w_word = {r_shift, w_bit};

    always_comb begin
        w_state_nxt = r_state;
        w_zcnt_nxt  = r_zcnt;
        w_bcnt_nxt  = r_bcnt;
        w_shift_nxt = r_shift;
        w_pidx_nxt  = r_pidx;
        w_frame_ok  = 1'b0;
        w_hdr_bad   = 1'b0;
        w_done      = 1'b0;
        if (w_tmo) begin
            w_state_nxt = IDLE;
            w_zcnt_nxt  = '0;
            w_bcnt_nxt  = '0;
        end else if (w_fall) begin
            unique case (r_state)
                IDLE: begin
                    if (w_bit) begin
                        w_zcnt_nxt = '0;
                    end else if (r_zcnt == ZLAST) begin
                        w_state_nxt = SYNC;
                        w_zcnt_nxt  = '0;
                        w_pidx_nxt  = '0;
                    end else begin
                        w_zcnt_nxt = r_zcnt + 1'b1;
                    end
                end
                SYNC: begin
                    if (w_bit) begin
                        w_state_nxt = LED;
                        w_bcnt_nxt  = CW'(1);
                        w_shift_nxt = (FRAME_BITS-1)'(1);
                    end
                end
                LED: begin
                    w_shift_nxt = w_word[FRAME_BITS-2:0];
                    w_bcnt_nxt  = r_bcnt + 1'b1;
                    if (r_bcnt == BLAST) begin
                        w_bcnt_nxt = '0;
                        w_zcnt_nxt = '0;
                        if (w_word[FRAME_BITS-1 -: 3] == HDR) begin
                            w_frame_ok  = 1'b1;
                            w_state_nxt = GAP;
                            if (r_pidx != PW'(MAX_PIXELS)) begin
                                w_pidx_nxt = r_pidx + 1'b1;
                            end
                        end else begin
                            w_hdr_bad   = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end
                end
                GAP: begin
                    if (w_bit) begin
                        w_state_nxt = LED;
                        w_bcnt_nxt  = CW'(1);
                        w_shift_nxt = (FRAME_BITS-1)'(1);
                        w_zcnt_nxt  = '0;
                    end else if (r_zcnt == ZLAST) begin
                        w_done      = 1'b1;
                        w_state_nxt = SYNC;
                        w_zcnt_nxt  = '0;
                        w_pidx_nxt  = '0;
                    end else begin
                        w_zcnt_nxt = r_zcnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign w_pix     = make_pix(w_word[28:0], int'(r_pidx), MAT_W);
    assign w_room    = (r_pidx < PW'(MAX_PIXELS));
    assign w_valid   = ~w_empty;
    assign w_pop     = w_valid & pix_ready;
    assign w_wr      = w_frame_ok & w_room & (~w_full | w_pop);
    assign w_ovf_set = w_frame_ok & w_room & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_sdat_meta <= 1'b0;
            r_sdat_sync <= 1'b0;
            r_state     <= IDLE;
            r_zcnt      <= '0;
            r_bcnt      <= '0;
            r_shift     <= '0;
            r_pidx      <= '0;
            r_idle_cnt  <= '0;
            r_done      <= 1'b0;
            r_hdr_err   <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_sclk_meta <= sclk_in;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_sdat_meta <= sdat_in;
            r_sdat_sync <= r_sdat_meta;
            r_state     <= w_state_nxt;
            r_zcnt      <= w_zcnt_nxt;
            r_bcnt      <= w_bcnt_nxt;
            r_shift     <= w_shift_nxt;
            r_pidx      <= w_pidx_nxt;
            r_done      <= w_done;
            if (w_fall) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != TW'(IDLE_TIMEOUT)) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
            if (w_hdr_bad) begin
                r_hdr_err <= 1'b1;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
        end
    end

    chrisruk_pix_fifo #(
        .WIDTH ($bits(pix_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr      (w_wr),
        .i_wr_data (w_pix),
        .i_rd      (pix_ready),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Head is masked so the stream reads all-zero when nothing is queued.
    assign w_head     = w_valid ? pix_t'(w_rd_data) : '0;
    assign pix_valid  = w_valid;
    assign pix_bright = w_head.bright;
    assign pix_b      = w_head.b;
    assign pix_g      = w_head.g;
    assign pix_r      = w_head.r;
    assign pix_x      = w_head.x;
    assign pix_y      = w_head.y;
    assign frame_done = r_done;
    assign hdr_err    = r_hdr_err;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_chrisruk_matrix_rx.sv
// Directed bench for chrisruk_matrix_rx: table-driven frame vectors plus
// hand-written sequences for overflow, header error, timeout and reset.
`timescale 1ns/1ps
module tb_chrisruk_matrix_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk_in;
    logic       sdat_in;
    logic       pix_ready;
    logic       pix_valid;
    logic [4:0] pix_bright;
    logic [7:0] pix_b;
    logic [7:0] pix_g;
    logic [7:0] pix_r;
    logic [2:0] pix_x;
    logic [2:0] pix_y;
    logic       frame_done;
    logic       hdr_err;
    logic       ovf;

    always #5 clk = ~clk;

    chrisruk_matrix_rx dut (
        .clk        (clk),
        .reset      (reset),
        .sclk_in    (sclk_in),
        .sdat_in    (sdat_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_bright (pix_bright),
        .pix_b      (pix_b),
        .pix_g      (pix_g),
        .pix_r      (pix_r),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .frame_done (frame_done),
        .hdr_err    (hdr_err),
        .ovf        (ovf)
    );

    typedef struct {
        logic [31:0] word;
        logic [4:0]  bright;
        logic [7:0]  b;
        logic [7:0]  g;
        logic [7:0]  r;
        logic [2:0]  x;
        logic [2:0]  y;
    } vec_t;

    vec_t        tbl[10];
    vec_t        t2[2];
    vec_t        fresh;
    logic [36:0] got[$];
    int          done_cnt = 0;
    int          checks   = 0;
    int          failures = 0;

    always @(negedge clk) begin
        if (!reset && pix_valid && pix_ready) begin
            got.push_back({pix_bright, pix_b, pix_g, pix_r, pix_x, pix_y});
        end
        if (frame_done) begin
            done_cnt++;
        end
    end

    function automatic logic [36:0] expv(input vec_t v);
        return {v.bright, v.b, v.g, v.r, v.x, v.y};
    endfunction

    function automatic logic [36:0] getq(input int i);
        if (i < got.size()) return got[i];
        return '1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        sdat_in = b;
        sclk_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        sclk_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic send_word(input logic [31:0] w, input int nbits);
        for (int i = 31; i > 31 - nbits; i--) send_bit(w[i]);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        sclk_in = 1'b0;
        sdat_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        got.delete();
        done_cnt = 0;
    endtask

    task automatic settle();
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{32'hE1010203, 5'd1,  8'h01, 8'h02, 8'h03, 3'd7, 3'd0};
        tbl[1] = '{32'hE2111213, 5'd2,  8'h11, 8'h12, 8'h13, 3'd6, 3'd0};
        tbl[2] = '{32'hE3212223, 5'd3,  8'h21, 8'h22, 8'h23, 3'd5, 3'd0};
        tbl[3] = '{32'hE4313233, 5'd4,  8'h31, 8'h32, 8'h33, 3'd4, 3'd0};
        tbl[4] = '{32'hE5414243, 5'd5,  8'h41, 8'h42, 8'h43, 3'd3, 3'd0};
        tbl[5] = '{32'hE6515253, 5'd6,  8'h51, 8'h52, 8'h53, 3'd2, 3'd0};
        tbl[6] = '{32'hE7616263, 5'd7,  8'h61, 8'h62, 8'h63, 3'd1, 3'd0};
        tbl[7] = '{32'hE8717273, 5'd8,  8'h71, 8'h72, 8'h73, 3'd0, 3'd0};
        tbl[8] = '{32'hE9818283, 5'd9,  8'h81, 8'h82, 8'h83, 3'd0, 3'd1};
        tbl[9] = '{32'hEA919293, 5'd10, 8'h91, 8'h92, 8'h93, 3'd1, 3'd1};
        t2[0]  = '{32'hF00F0000, 5'b10000, 8'h0F, 8'h00, 8'h00, 3'd7, 3'd0};
        t2[1]  = '{32'hF0000000, 5'b10000, 8'h00, 8'h00, 8'h00, 3'd6, 3'd0};
        fresh  = '{32'hF0112233, 5'b10000, 8'h11, 8'h22, 8'h33, 3'd7, 3'd0};

        pix_ready = 1'b1;
        @(posedge clk);
        #1;

        // 1: reset state, then random bits stay in IDLE
        do_reset();
        @(negedge clk);
        chk("reset_outputs",
            {pix_valid, pix_bright, pix_b, pix_g, pix_r, pix_x, pix_y,
             frame_done, hdr_err, ovf}, '0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
        settle();
        chk("rand_no_push_valid", pix_valid, 0);
        chk("rand_no_push_cnt", got.size(), 0);

        // 2: two frames and one end frame
        send_zeros(32);
        for (int i = 0; i < 2; i++) send_word(t2[i].word, 32);
        send_zeros(64);
        settle();
        chk("t2_count", got.size(), 2);
        for (int i = 0; i < 2; i++) chk($sformatf("t2_pix%0d", i), getq(i), expv(t2[i]));
        chk("t2_done", done_cnt, 1);

        // 3: serpentine decode over 10 frames
        do_reset();
        send_zeros(32);
        for (int i = 0; i < 10; i++) send_word(tbl[i].word, 32);
        send_zeros(32);
        settle();
        chk("t3_count", got.size(), 10);
        for (int i = 0; i < 10; i++) chk($sformatf("t3_pix%0d", i), getq(i), expv(tbl[i]));

        // 3b: 70 frames, only MAX_PIXELS accepted
        do_reset();
        send_zeros(32);
        for (int i = 0; i < 70; i++) send_word({8'hE3, 8'(i), 16'hA55A}, 32);
        send_zeros(32);
        settle();
        chk("t3b_count", got.size(), 64);
        chk("t3b_ovf", ovf, 0);
        chk("t3b_first", getq(0), {5'd3, 8'h00, 8'hA5, 8'h5A, 3'd7, 3'd0});
        chk("t3b_last", getq(63), {5'd3, 8'h3F, 8'hA5, 8'h5A, 3'd7, 3'd7});
        chk("t3b_done", done_cnt, 1);

        // 4: backpressure overflow, then drain in order
        do_reset();
        pix_ready = 1'b0;
        send_zeros(32);
        for (int i = 0; i < 6; i++) send_word(tbl[i].word, 32);
        send_zeros(32);
        settle();
        chk("t4_ovf", ovf, 1);
        chk("t4_valid", pix_valid, 1);
        chk("t4_head_stable",
            {pix_bright, pix_b, pix_g, pix_r, pix_x, pix_y}, expv(tbl[0]));
        chk("t4_no_pop", got.size(), 0);
        pix_ready = 1'b1;
        settle();
        chk("t4_drain_count", got.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t4_drain%0d", i), getq(i), expv(tbl[i]));
        chk("t4_ovf_sticky", ovf, 1);

        // 4b: push into a full FIFO on the same clk as a pop
        do_reset();
        pix_ready = 1'b0;
        send_zeros(32);
        for (int i = 0; i < 4; i++) send_word(tbl[i].word, 32);
        send_word(tbl[4].word, 31);
        sdat_in = tbl[4].word[0];
        sclk_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        sclk_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        pix_ready = 1'b1;
        @(posedge clk);
        #1;
        pix_ready = 1'b0;
        send_zeros(32);
        settle();
        chk("t4b_ovf", ovf, 0);
        pix_ready = 1'b1;
        settle();
        chk("t4b_count", got.size(), 5);
        chk("t4b_pushed", getq(4), expv(tbl[4]));

        // 5: bad header flagged and dropped, resync works
        do_reset();
        send_zeros(32);
        send_word(32'hA0FF0000, 32);
        settle();
        chk("t5_hdr_err", hdr_err, 1);
        chk("t5_no_push", got.size(), 0);
        send_zeros(32);
        send_word(fresh.word, 32);
        send_zeros(32);
        settle();
        chk("t5_count", got.size(), 1);
        chk("t5_pix", getq(0), expv(fresh));
        chk("t5_hdr_sticky", hdr_err, 1);

        // 6: strip clock stalls mid-frame past the timeout
        do_reset();
        send_zeros(32);
        send_word(32'hF0AA0000, 16);
        repeat (4200) @(posedge clk);
        #1;
        send_zeros(32);
        send_word(fresh.word, 32);
        send_zeros(32);
        settle();
        chk("t6_tmo_count", got.size(), 1);
        chk("t6_tmo_pix", getq(0), expv(fresh));
        chk("t6_tmo_done", done_cnt, 1);

        // 6b: reset mid-frame
        do_reset();
        send_zeros(32);
        send_word(32'hF0AA0000, 16);
        do_reset();
        send_zeros(32);
        send_word(fresh.word, 32);
        send_zeros(32);
        settle();
        chk("t6_rst_count", got.size(), 1);
        chk("t6_rst_pix", getq(0), expv(fresh));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
